mp_ser_scheduler: RTL and testbench



---
 rtl/mp_ser_pkg.sv | 30 +++
 rtl/mp_ser_rr_arb.sv | 34 +++
 rtl/mp_ser_scheduler.sv | 128 ++++++++++++
 tb/tb_mp_ser_scheduler.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mp_ser_pkg.sv
// Shared types and frame-word helpers for the serializer scheduler.
// Lane helpers return a MAX_LANE_W-bit word; callers keep the low width_p bits.
package mp_ser_pkg;

    typedef enum logic {
        TRAIN = 1'b0,
        RUN   = 1'b1
    } state_e;

    localparam int MAX_LANE_W = 64;

    function automatic logic [MAX_LANE_W-1:0] lane_mask(input int width);
        logic [MAX_LANE_W-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_LANE_W; i++) begin
            if (i < width) m[i] = 1'b1;
        end
        return m;
    endfunction

    // Alternating 1/0 from the MSB gives the receiver a clean transition-rich pattern.
    function automatic logic [MAX_LANE_W-1:0] train_lane(input int width);
        return {(MAX_LANE_W/2){2'b10}} & lane_mask(width);
    endfunction

    function automatic logic [MAX_LANE_W-1:0] idle_lane(input int width);
        return '0 & lane_mask(width);
    endfunction

endpackage

// File: rtl/mp_ser_rr_arb.sv
// Combinational round-robin arbiter: searches upward from last_grant+1 (mod num_req_p).
// The pointer register is owned by the caller.
module mp_ser_rr_arb #(
    parameter int num_req_p = 2,
    localparam int idx_w = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
    input  logic [num_req_p-1:0] req_v,
    input  logic                 en,
    input  logic [idx_w-1:0]     last_grant,
    output logic [num_req_p-1:0] grant_oh,
    output logic [idx_w-1:0]     grant_idx,
    output logic                 grant_v
);

    always_comb begin
        int w_j;
        w_j       = 0;
        grant_oh  = '0;
        grant_idx = '0;
        grant_v   = 1'b0;
        if (en) begin
            for (int k = 1; k <= num_req_p; k++) begin
                w_j = int'(last_grant) + k;
                if (w_j >= num_req_p) w_j = w_j - num_req_p;
                if (!grant_v && req_v[w_j]) begin
                    grant_v       = 1'b1;
                    grant_idx     = idx_w'(w_j);
                    grant_oh[w_j] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mp_ser_scheduler.sv
// Shares one serializer between num_req_p requesters: training bursts, then
// round-robin granted frames or idle frames, one registered frame per cycle.
module mp_ser_scheduler
    import mp_ser_pkg::*;
#(
    parameter int width_p        = 16,
    parameter int els_p          = 4,
    parameter int num_req_p      = 2,
    parameter int train_frames_p = 16,
    parameter int cnt_width_p    = 16
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic [num_req_p-1:0]               req_v_i,
    input  logic [num_req_p*width_p*els_p-1:0] req_data_i,
    output logic [num_req_p-1:0]               req_yumi_o,
    input  logic                               retrain_i,
    output logic [width_p*els_p-1:0]           frame_data_o,
    output logic                               frame_v_o,
    output logic                               train_o,
    output logic [cnt_width_p-1:0]             frame_cnt_o
);

    localparam int frame_w = width_p * els_p;
    localparam int tcnt_w  = (train_frames_p > 1) ? $clog2(train_frames_p) : 1;
    localparam int ptr_w   = (num_req_p > 1) ? $clog2(num_req_p) : 1;

    localparam logic [tcnt_w-1:0]     TRAIN_LAST = tcnt_w'(train_frames_p - 1);
    localparam logic [ptr_w-1:0]      PTR_RESET  = ptr_w'(num_req_p - 1);
    localparam logic [MAX_LANE_W-1:0] TRAIN_LANE = train_lane(width_p);
    localparam logic [MAX_LANE_W-1:0] IDLE_LANE  = idle_lane(width_p);
    localparam logic [frame_w-1:0]    TRAIN_FRAME = {els_p{TRAIN_LANE[width_p-1:0]}};
    localparam logic [frame_w-1:0]    IDLE_FRAME  = {els_p{IDLE_LANE[width_p-1:0]}};

    state_e                 r_state, w_state_nxt;
    logic [tcnt_w-1:0]      r_tcnt, w_tcnt_nxt;
    logic [ptr_w-1:0]       r_last_grant, w_last_grant_nxt;
    logic [frame_w-1:0]     r_frame_data, w_frame_data_nxt;
    logic                   r_frame_v, w_frame_v_nxt;
    logic                   r_train, w_train_nxt;
    logic [cnt_width_p-1:0] r_frame_cnt, w_frame_cnt_nxt;

    logic                   w_arb_en;
    logic [num_req_p-1:0]   w_gnt_oh;
    logic [ptr_w-1:0]       w_gnt_idx;
    logic                   w_gnt_v;

    // Gating with reset_i keeps yumi low while the FSM state is still stale.
    assign w_arb_en = (r_state == RUN) && !retrain_i && !reset_i;

    mp_ser_rr_arb #(
        .num_req_p (num_req_p)
    ) u_arb (
        .req_v      (req_v_i),
        .en         (w_arb_en),
        .last_grant (r_last_grant),
        .grant_oh   (w_gnt_oh),
        .grant_idx  (w_gnt_idx),
        .grant_v    (w_gnt_v)
    );

    assign req_yumi_o = w_gnt_oh;

    always_comb begin
        w_state_nxt      = r_state;
        w_tcnt_nxt       = r_tcnt;
        w_last_grant_nxt = r_last_grant;
        w_frame_data_nxt = IDLE_FRAME;
        w_frame_v_nxt    = 1'b0;
        w_train_nxt      = 1'b0;
        w_frame_cnt_nxt  = r_frame_cnt;
        case (r_state)
            TRAIN: begin
                w_frame_data_nxt = TRAIN_FRAME;
                w_train_nxt      = 1'b1;
                if (retrain_i) begin
                    w_tcnt_nxt = '0;
                end else if (r_tcnt == TRAIN_LAST) begin
                    w_state_nxt = RUN;
                    w_tcnt_nxt  = '0;
                end else begin
                    w_tcnt_nxt = r_tcnt + 1'b1;
                end
            end
            RUN: begin
                if (retrain_i) begin
                    w_state_nxt = TRAIN;
                    w_tcnt_nxt  = '0;
                end else if (w_gnt_v) begin
                    w_frame_data_nxt = req_data_i[w_gnt_idx*frame_w +: frame_w];
                    w_frame_v_nxt    = 1'b1;
                    w_last_grant_nxt = w_gnt_idx;
                    w_frame_cnt_nxt  = r_frame_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = TRAIN;
                w_tcnt_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state      <= TRAIN;
            r_tcnt       <= '0;
            r_last_grant <= PTR_RESET;
            r_frame_data <= '0;
            r_frame_v    <= 1'b0;
            r_train      <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_tcnt       <= w_tcnt_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_frame_data <= w_frame_data_nxt;
            r_frame_v    <= w_frame_v_nxt;
            r_train      <= w_train_nxt;
            r_frame_cnt  <= w_frame_cnt_nxt;
        end
    end

    assign frame_data_o = r_frame_data;
    assign frame_v_o    = r_frame_v;
    assign train_o      = r_train;
    assign frame_cnt_o  = r_frame_cnt;

endmodule

// File: tb/tb_mp_ser_scheduler.sv
// Scoreboard bench for mp_ser_scheduler: a per-cycle behavioural model pushes
// expected yumi and registered outputs; a monitor pops and compares them.
module tb_mp_ser_scheduler;

    localparam int W  = 16;
    localparam int E  = 4;
    localparam int N  = 2;
    localparam int TF = 16;
    localparam int CW = 4;
    localparam int FW = W * E;

    localparam logic [FW-1:0] TRAIN_WORD = 64'hAAAA_AAAA_AAAA_AAAA;

    logic              clk = 1'b0;
    logic              reset_i;
    logic              retrain_i;
    logic [N-1:0]      req_v_i;
    logic [N*FW-1:0]   req_data_i;
    logic [N-1:0]      req_yumi_o;
    logic [FW-1:0]     frame_data_o;
    logic              frame_v_o;
    logic              train_o;
    logic [CW-1:0]     frame_cnt_o;

    always #5 clk = ~clk;

    mp_ser_scheduler #(
        .width_p        (W),
        .els_p          (E),
        .num_req_p      (N),
        .train_frames_p (TF),
        .cnt_width_p    (CW)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .req_v_i      (req_v_i),
        .req_data_i   (req_data_i),
        .req_yumi_o   (req_yumi_o),
        .retrain_i    (retrain_i),
        .frame_data_o (frame_data_o),
        .frame_v_o    (frame_v_o),
        .train_o      (train_o),
        .frame_cnt_o  (frame_cnt_o)
    );

    typedef struct packed {
        logic [FW-1:0] data;
        logic          v;
        logic          t;
        logic [CW-1:0] cnt;
    } out_t;

    out_t         exp_out_q[$];
    logic [N-1:0] exp_yumi_q[$];
    int           n_tests = 0;
    int           n_fail  = 0;

    // Model: frames of training still owed, round-robin pointer, frames sent.
    int m_train_left = TF;
    int m_last       = N - 1;
    int m_cnt        = 0;

    bit            pend  [N];
    logic [FW-1:0] pdata [N];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_cycle(input bit rst, input bit rt, input int p_valid);
        logic [N-1:0] y;
        out_t         o;
        int           g;
        int           j;
        for (int i = 0; i < N; i++) begin
            if (!pend[i] && int'($urandom_range(99)) < p_valid) begin
                pend[i]  = 1'b1;
                pdata[i] = {$urandom, $urandom};
            end
        end
        reset_i   = rst;
        retrain_i = rt;
        for (int i = 0; i < N; i++) begin
            req_v_i[i]             = pend[i];
            req_data_i[i*FW +: FW] = pdata[i];
        end
        y = '0;
        o = '0;
        if (rst) begin
            m_train_left = TF;
            m_last       = N - 1;
            m_cnt        = 0;
        end else if (m_train_left > 0) begin
            o.data       = TRAIN_WORD;
            o.t          = 1'b1;
            m_train_left = rt ? TF : m_train_left - 1;
        end else if (rt) begin
            m_train_left = TF;
        end else begin
            g = -1;
            for (int k = 1; k <= N; k++) begin
                j = (m_last + k) % N;
                if (g < 0 && pend[j]) g = j;
            end
            if (g >= 0) begin
                y[g]    = 1'b1;
                o.data  = pdata[g];
                o.v     = 1'b1;
                m_cnt   = (m_cnt + 1) % (1 << CW);
                m_last  = g;
                pend[g] = 1'b0;
            end
        end
        o.cnt = CW'(m_cnt);
        exp_yumi_q.push_back(y);
        exp_out_q.push_back(o);
        @(negedge clk);
    endtask

    task automatic run(input int n, input int p_valid, input int p_retrain);
        for (int c = 0; c < n; c++)
            do_cycle(1'b0, int'($urandom_range(999)) < p_retrain, p_valid);
    endtask

    // Monitor: yumi mid-low-phase, registered outputs just after the edge.
    initial begin
        logic [N-1:0] ey;
        out_t         eo;
        forever begin
            @(negedge clk);
            #2;
            if (exp_yumi_q.size() > 0) begin
                ey = exp_yumi_q.pop_front();
                chk("yumi", 64'(req_yumi_o), 64'(ey));
                @(posedge clk);
                #1;
                eo = exp_out_q.pop_front();
                chk("frame_data", frame_data_o, eo.data);
                chk("frame_v", 64'(frame_v_o), 64'(eo.v));
                chk("train", 64'(train_o), 64'(eo.t));
                chk("frame_cnt", 64'(frame_cnt_o), 64'(eo.cnt));
            end
        end
    end

    initial begin
        reset_i    = 1'b1;
        retrain_i  = 1'b0;
        req_v_i    = '0;
        req_data_i = '0;
        for (int i = 0; i < N; i++) begin
            pend[i]  = 1'b0;
            pdata[i] = '0;
        end
        @(negedge clk);
        for (int c = 0; c < 3; c++) do_cycle(1'b1, 1'b0, 0);
        // Training burst with no traffic, then idle frames.
        run(22, 0, 0);
        // Single directed frame from requester 0.
        pend[0]  = 1'b1;
        pdata[0] = 64'h0001_0002_0003_0004;
        run(3, 0, 0);
        // Both requesters saturated: strict alternation.
        run(6, 100, 0);
        // Retrain pulse under load, then recover.
        do_cycle(1'b0, 1'b1, 100);
        run(22, 100, 0);
        // Random traffic with occasional retrain.
        run(250, 60, 25);
        // Reset in the middle of a burst.
        run(4, 100, 0);
        do_cycle(1'b1, 1'b0, 100);
        run(24, 100, 0);
        // Saturated traffic long enough to wrap the 4-bit counter.
        run(40, 100, 0);
        run(60, 50, 0);
        repeat (3) @(negedge clk);
        chk("queue_drain", 64'(exp_out_q.size() + exp_yumi_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
